// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide data memory.
// Runs one request at a time; sub-word stores use a read-modify-write pair of cycles.
module mem_access_unit #(
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        Err,
  output logic        StallM,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_RESP, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;
  logic [31:0] resp_data_q;
  logic        illegal;

  // Bit position of the addressed lane's LSB inside the memory word.
  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd0:    lane_shift = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
      2'd1:    lane_shift = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
      default: lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic        [31:0] sh;
    logic signed [31:0] ext;
    sh = rd >> lane_shift(off, size);
    case (size)
      2'd0:    ext = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      2'd1:    ext = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: ext = rd;
    endcase
    extract_load = ext;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [15:0] wd,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh   = lane_shift(off, size);
    mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_store = (rd & ~mask) | (({16'd0, wd} << sh) & mask);
  endfunction

  assign illegal = (ReqSize == 2'd3)
                || (CHECK_ALIGN && (ReqSize == 2'd1) && ReqAddr[0])
                || (CHECK_ALIGN && (ReqSize == 2'd2) && (ReqAddr[1:0] != 2'b00));

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ReqReady  = 1'b0;
    RespValid = 1'b0;
    Err       = 1'b0;
    MemWE     = 1'b0;
    StallM    = 1'b1;
    case (state)
      S_IDLE: begin
        ReqReady = 1'b1;
        StallM   = 1'b0;
        if (ReqValid) begin
          if (illegal)               state_nxt = S_ERR;
          else if (!ReqWrite)        state_nxt = S_LOAD;
          else if (ReqSize == 2'd2)  state_nxt = S_WRITE;
          else                       state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_RESP;
      S_WRITE: begin
        MemWE     = 1'b1;
        state_nxt = S_RESP;
      end
      S_RMW_RD: state_nxt = S_RMW_WR;
      S_RMW_WR: begin
        MemWE     = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        RespValid = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        Err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields captured at accept; only used while busy, so no reset needed.
  always_ff @(posedge CLK) begin
    if ((state == S_IDLE) && ReqValid) begin
      off_q    <= ReqAddr[1:0];
      size_q   <= ReqSize;
      signed_q <= ReqSigned;
      wdata_q  <= ReqWData[15:0];
    end
  end

  // Memory-facing and response registers keep the bus glitch-free.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem_a_q     <= 32'd0;
      mem_wd_q    <= 32'd0;
      resp_data_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (ReqValid) begin
          resp_data_q <= 32'd0;
          if (!illegal) begin
            mem_a_q  <= {ReqAddr[31:2], 2'b00};
            mem_wd_q <= ReqWData;
          end
        end
        S_LOAD:   resp_data_q <= extract_load(MemRD, off_q, size_q, signed_q);
        S_RMW_RD: mem_wd_q    <= merge_store(MemRD, wdata_q, off_q, size_q);
        default:  ;
      endcase
    end
  end

  assign MemA     = mem_a_q;
  assign MemWD    = mem_wd_q;
  assign RespData = resp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory (write on posedge, RD on negedge).
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'd0;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqWData = 32'd0;
  logic        ReqReady, RespValid, Err, StallM, MemWE;
  logic [31:0] RespData, MemA, MemWD;
  logic [31:0] MemRD = 32'd0;

  logic [31:0] mem [0:1023];
  int          we_total = 0;
  int          checks = 0;
  int          failures = 0;

  int          lat, st, we;
  logic [31:0] rd, as, ws;
  logic        e, r;

  mem_access_unit #(.BIG_ENDIAN(1'b1), .CHECK_ALIGN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid),
    .RespData(RespData), .Err(Err), .StallM(StallM), .MemA(MemA),
    .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MemWE) begin
      mem[MemA[11:2]] <= MemWD;
      we_total <= we_total + 1;
    end
  end

  always @(negedge CLK) MemRD <= mem[MemA[11:2]];

  // Drives one request, waits for its response/error, returns observations; caller ends in IDLE.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0; lat = -1; rd = '0; e = 1'b0; r = 1'b0; st = 0; we = 0; as = '0; ws = '0;
    ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd; ReqValid = 1'b1;
    while (!ReqReady && n < 20) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    ReqValid = 1'b0; ReqAddr = 32'hFFFF_FFFF; ReqWData = 32'h5A5A_5A5A;
    ReqSize = 2'd3; ReqWrite = ~w; ReqSigned = ~sg;
    for (int c = 1; c <= 8; c++) begin
      if (StallM) st++;
      if (MemWE) begin we++; as = MemA; ws = MemWD; end
      if (RespValid || Err) begin lat = c; rd = RespData; e = Err; r = RespValid; break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqAddr = 32'h400; ReqWData = 32'hCAFE_F00D;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (ReqReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ReqReady); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", StallM); end
    checks++; if ({RespValid, Err, MemWE} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b exp=000", {RespValid, Err, MemWE}); end
    checks++; if (MemA !== 32'd0) begin failures++; $display("FAIL rst_mema got=%h exp=0", MemA); end
    checks++; if (MemWD !== 32'd0) begin failures++; $display("FAIL rst_memwd got=%h exp=0", MemWD); end
    checks++; if (RespData !== 32'd0) begin failures++; $display("FAIL rst_respdata got=%h exp=0", RespData); end
    checks++; if (we_total !== 0) begin failures++; $display("FAIL rst_no_write got=%0d exp=0", we_total); end
    ReqValid = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++; if ({ReqReady, StallM} !== 2'b10) begin failures++; $display("FAIL rst_release got=%b exp=10", {ReqReady, StallM}); end
  endtask

  task automatic test_word_store_load();
    run_req(1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (we !== 1) begin failures++; $display("FAIL sw_we_cycles got=%0d exp=1", we); end
    checks++; if (as !== 32'h404) begin failures++; $display("FAIL sw_mema got=%h exp=00000404", as); end
    checks++; if (ws !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_memwd got=%h exp=deadbeef", ws); end
    checks++; if (st !== 2) begin failures++; $display("FAIL sw_stall got=%0d exp=2", st); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL sw_respdata got=%h exp=0", rd); end
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0404, 32'd0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++; if (we !== 0) begin failures++; $display("FAIL lw_no_we got=%0d exp=0", we); end
  endtask

  task automatic test_subword_loads();
    run_req(1'b1, 2'd2, 1'b0, 32'h0000_0408, 32'h80FF_7F01);
    run_req(1'b0, 2'd0, 1'b1, 32'h0000_0408, 32'd0);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_408 got=%h exp=ffffff80", rd); end
    run_req(1'b0, 2'd0, 1'b0, 32'h0000_0409, 32'd0);
    checks++; if (rd !== 32'h0000_00FF) begin failures++; $display("FAIL lbu_409 got=%h exp=000000ff", rd); end
    run_req(1'b0, 2'd0, 1'b1, 32'h0000_040A, 32'd0);
    checks++; if (rd !== 32'h0000_007F) begin failures++; $display("FAIL lb_40a got=%h exp=0000007f", rd); end
    run_req(1'b0, 2'd1, 1'b1, 32'h0000_040A, 32'd0);
    checks++; if (rd !== 32'h0000_7F01) begin failures++; $display("FAIL lh_40a got=%h exp=00007f01", rd); end
    run_req(1'b0, 2'd1, 1'b1, 32'h0000_0408, 32'd0);
    checks++; if (rd !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_408 got=%h exp=ffff80ff", rd); end
    run_req(1'b0, 2'd0, 1'b0, 32'h0000_0408, 32'd0);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_408 got=%h exp=00000080", rd); end
    run_req(1'b0, 2'd2, 1'b1, 32'h0000_0408, 32'd0);
    checks++; if (rd !== 32'h80FF_7F01) begin failures++; $display("FAIL lw_signed got=%h exp=80ff7f01", rd); end
  endtask

  task automatic test_rmw();
    run_req(1'b1, 2'd2, 1'b0, 32'h0000_040C, 32'h1122_3344);
    run_req(1'b1, 2'd0, 1'b0, 32'h0000_040D, 32'hFFFF_FFAA);
    checks++; if (lat !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
    checks++; if (we !== 1) begin failures++; $display("FAIL sb_we_cycles got=%0d exp=1", we); end
    checks++; if (ws !== 32'h11AA_3344) begin failures++; $display("FAIL sb_merge got=%h exp=11aa3344", ws); end
    checks++; if (as !== 32'h40C) begin failures++; $display("FAIL sb_mema got=%h exp=0000040c", as); end
    checks++; if (st !== 3) begin failures++; $display("FAIL sb_stall got=%0d exp=3", st); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL sb_respdata got=%h exp=0", rd); end
    run_req(1'b1, 2'd1, 1'b0, 32'h0000_040E, 32'hFFFF_BEEF);
    checks++; if (ws !== 32'h11AA_BEEF) begin failures++; $display("FAIL sh_merge got=%h exp=11aabeef", ws); end
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_040C, 32'd0);
    checks++; if (rd !== 32'h11AA_BEEF) begin failures++; $display("FAIL rmw_readback got=%h exp=11aabeef", rd); end
  endtask

  task automatic test_errors();
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0406, 32'd0);
    checks++; if ({lat == 1, e, r, we == 0} !== 4'b1101) begin failures++; $display("FAIL err_lw406 got lat=%0d err=%b resp=%b we=%0d exp lat=1 err=1 resp=0 we=0", lat, e, r, we); end
    run_req(1'b1, 2'd1, 1'b0, 32'h0000_0407, 32'h0000_BEEF);
    checks++; if ({lat == 1, e, r, we == 0} !== 4'b1101) begin failures++; $display("FAIL err_sh407 got lat=%0d err=%b resp=%b we=%0d exp lat=1 err=1 resp=0 we=0", lat, e, r, we); end
    checks++; if (st !== 1) begin failures++; $display("FAIL err_stall got=%0d exp=1", st); end
    run_req(1'b1, 2'd3, 1'b0, 32'h0000_0404, 32'h1234_5678);
    checks++; if ({lat == 1, e, r, we == 0} !== 4'b1101) begin failures++; $display("FAIL err_size3 got lat=%0d err=%b resp=%b we=%0d exp lat=1 err=1 resp=0 we=0", lat, e, r, we); end
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0404, 32'd0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL err_mem_intact got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_reset_mid_rmw();
    int we0, bad;
    run_req(1'b1, 2'd2, 1'b0, 32'h0000_0410, 32'h0102_0304);
    we0 = we_total; bad = 0;
    ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0; ReqAddr = 32'h410; ReqWData = 32'h55; ReqValid = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    checks++; if ({StallM, MemWE} !== 2'b10) begin failures++; $display("FAIL rmwrst_in_rd got=%b exp=10", {StallM, MemWE}); end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    checks++; if ({ReqReady, StallM, MemWE, RespValid} !== 4'b1000) begin failures++; $display("FAIL rmwrst_idle got=%b exp=1000", {ReqReady, StallM, MemWE, RespValid}); end
    repeat (4) begin
      if (MemWE || RespValid || Err) bad++;
      @(posedge CLK); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rmwrst_quiet got=%0d exp=0", bad); end
    checks++; if (we_total !== we0) begin failures++; $display("FAIL rmwrst_no_write got=%0d exp=%0d", we_total, we0); end
    run_req(1'b0, 2'd2, 1'b0, 32'h0000_0410, 32'd0);
    checks++; if (rd !== 32'h0102_0304) begin failures++; $display("FAIL rmwrst_mem got=%h exp=01020304", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] expd  [3];
    logic [31:0] got   [3];
    int          acc   [3];
    int          rsp   [3];
    int          ai, ri;
    logic        accepted;
    addrs = '{32'h404, 32'h408, 32'h40C};
    expd  = '{32'hDEAD_BEEF, 32'h80FF_7F01, 32'h11AA_BEEF};
    got = '{default: '0}; acc = '{default: 0}; rsp = '{default: 0};
    ai = 0; ri = 0;
    ReqWrite = 1'b0; ReqSize = 2'd2; ReqSigned = 1'b0; ReqAddr = addrs[0]; ReqValid = 1'b1;
    for (int cyc = 0; cyc < 40 && ri < 3; cyc++) begin
      accepted = 1'b0;
      if (RespValid && ri < 3) begin rsp[ri] = cyc; got[ri] = RespData; ri++; end
      if (ReqValid && ReqReady && ai < 3) begin acc[ai] = cyc; ai++; accepted = 1'b1; end
      @(posedge CLK); #1;
      if (accepted) begin
        if (ai < 3) ReqAddr = addrs[ai];
        else        ReqValid = 1'b0;
      end
    end
    ReqValid = 1'b0;
    @(posedge CLK); #1;
    checks++; if (ai !== 3 || ri !== 3) begin failures++; $display("FAIL b2b_count got acc=%0d resp=%0d exp 3/3", ai, ri); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== expd[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got[i], expd[i]); end
      checks++; if (rsp[i] - acc[i] !== 2) begin failures++; $display("FAIL b2b_lat%0d got=%0d exp=2", i, rsp[i] - acc[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (acc[i+1] !== rsp[i] + 1) begin failures++; $display("FAIL b2b_next_accept%0d got=%0d exp=%0d", i, acc[i+1], rsp[i] + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
